// File: rtl/l1_to_l2_arbiter.sv
// ---------------------------------------------------------------------------
// l1_to_l2_arbiter
//
// Purpose: shares one L2CACHE request port between the ICACHE and the DCACHE.
// There is exactly one transaction in flight at a time. Requesters are
// granted round-robin, and the granted request is held stable towards L2.
// The L2 response is routed back to the owner as a one-cycle pulse.
//
// Handshake semantics: a request transfers on a rising edge where valid and
// ready are both high. Ready may depend combinationally on valid. Valid does
// not depend on ready. Once l2_req_valid rises, it and all l2_req_* fields
// stay unchanged until the cycle in which l2_req_ready is seen high.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   ic_req_*          ICACHE fill request (always LOAD / WORD)
//   ic_rsp_*          ICACHE response (valid is a one-cycle pulse)
//   dc_req_*          DCACHE request (STORE / LOAD / CLFLUSH, any size)
//   dc_rsp_*          DCACHE response (valid is a one-cycle pulse)
//   l2_req_*          held request towards L2, with the owner in l2_req_src
//   l2_rsp_*          L2 response; it acknowledges every operation
//   fsm_state         debug view of the FSM: 0 = IDLE, 1 = ISSUE, 2 = WAIT_RSP
//
// Encodings:
//   op:   STORE = 0, LOAD = 1, CLFLUSH = 2
//   size: BYTE = 0, HALF = 1, WORD = 2
//   src:  UNASSIGNED = 0, ICACHE = 1, DCACHE = 2
// ---------------------------------------------------------------------------
module l1_to_l2_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_rsp_valid,
    output logic [DATA_W-1:0] ic_rsp_data,

    input  logic              dc_req_valid,
    input  logic [1:0]        dc_req_op,
    input  logic [1:0]        dc_req_size,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [DATA_W-1:0] dc_req_wdata,
    output logic              dc_req_ready,
    output logic              dc_rsp_valid,
    output logic [DATA_W-1:0] dc_rsp_data,

    output logic              l2_req_valid,
    output logic [1:0]        l2_req_op,
    output logic [1:0]        l2_req_size,
    output logic [ADDR_W-1:0] l2_req_addr,
    output logic [DATA_W-1:0] l2_req_wdata,
    output logic [1:0]        l2_req_src,
    input  logic              l2_req_ready,
    input  logic              l2_rsp_valid,
    input  logic [DATA_W-1:0] l2_rsp_data,

    output logic [1:0]        fsm_state
);

    localparam logic [1:0] OP_LOAD        = 2'd1;
    localparam logic [1:0] SIZE_WORD      = 2'd2;
    localparam logic [1:0] SRC_UNASSIGNED = 2'd0;
    localparam logic [1:0] SRC_ICACHE     = 2'd1;
    localparam logic [1:0] SRC_DCACHE     = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic                grant_ic;
    logic                grant_dc;
    // Set when the most recent grant went to the DCACHE. Reset clears it so
    // that the DCACHE wins the first tie.
    logic                last_dc_q;

    logic [1:0]          op_q;
    logic [1:0]          size_q;
    logic [1:0]          src_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                ic_rsp_valid_q;
    logic                dc_rsp_valid_q;
    logic [DATA_W-1:0]   ic_rsp_data_q;
    logic [DATA_W-1:0]   dc_rsp_data_q;

    // Next-state and grant logic. Grants are issued only in IDLE, and never
    // while reset is high, so that reset has priority over a waiting request.
    always_comb begin
        state_d  = state_q;
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (dc_req_valid && (!ic_req_valid || !last_dc_q)) begin
                        grant_dc = 1'b1;
                    end else if (ic_req_valid) begin
                        grant_ic = 1'b1;
                    end
                    if (grant_ic || grant_dc) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (l2_req_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (l2_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_dc_q      <= 1'b0;
            op_q           <= '0;
            size_q         <= '0;
            src_q          <= SRC_UNASSIGNED;
            addr_q         <= '0;
            wdata_q        <= '0;
            ic_rsp_valid_q <= 1'b0;
            dc_rsp_valid_q <= 1'b0;
            ic_rsp_data_q  <= '0;
            dc_rsp_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            ic_rsp_valid_q <= 1'b0;
            dc_rsp_valid_q <= 1'b0;

            if (grant_dc) begin
                op_q      <= dc_req_op;
                size_q    <= dc_req_size;
                addr_q    <= dc_req_addr;
                wdata_q   <= dc_req_wdata;
                src_q     <= SRC_DCACHE;
                last_dc_q <= 1'b1;
            end else if (grant_ic) begin
                op_q      <= OP_LOAD;
                size_q    <= SIZE_WORD;
                addr_q    <= ic_req_addr;
                wdata_q   <= '0;
                src_q     <= SRC_ICACHE;
                last_dc_q <= 1'b0;
            end

            // A response is accepted only in WAIT_RSP. In any other state,
            // l2_rsp_valid is a stray and is dropped.
            if (state_q == WAIT_RSP && l2_rsp_valid) begin
                if (src_q == SRC_ICACHE) begin
                    ic_rsp_valid_q <= 1'b1;
                    ic_rsp_data_q  <= l2_rsp_data;
                end else if (src_q == SRC_DCACHE) begin
                    dc_rsp_valid_q <= 1'b1;
                    dc_rsp_data_q  <= l2_rsp_data;
                end
            end
        end
    end

    assign ic_req_ready = grant_ic;
    assign dc_req_ready = grant_dc;
    assign ic_rsp_valid = ic_rsp_valid_q;
    assign dc_rsp_valid = dc_rsp_valid_q;
    assign ic_rsp_data  = ic_rsp_data_q;
    assign dc_rsp_data  = dc_rsp_data_q;

    assign l2_req_valid = (state_q == ISSUE);
    assign l2_req_op    = op_q;
    assign l2_req_size  = size_q;
    assign l2_req_addr  = addr_q;
    assign l2_req_wdata = wdata_q;
    assign l2_req_src   = src_q;

    assign fsm_state    = state_q;

endmodule

// File: tb/tb_l1_to_l2_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l1_to_l2_arbiter
//
// Purpose: self-checking bench for l1_to_l2_arbiter.
//
// Reference model: the bench tracks which requester should win the next tie,
// and the last response data that each cache received. Expected L2 fields
// come from the request that the model says wins. Inputs are driven 1 ns
// after the falling edge. Outputs are sampled 1 ns after that.
// ---------------------------------------------------------------------------
module tb_l1_to_l2_arbiter;

    localparam logic [1:0] OP_STORE   = 2'd0;
    localparam logic [1:0] OP_LOAD    = 2'd1;
    localparam logic [1:0] OP_CLFLUSH = 2'd2;
    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SRC_NONE   = 2'd0;
    localparam logic [1:0] SRC_IC     = 2'd1;
    localparam logic [1:0] SRC_DC     = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_ready;
    logic        ic_rsp_valid;
    logic [31:0] ic_rsp_data;
    logic        dc_req_valid;
    logic [1:0]  dc_req_op;
    logic [1:0]  dc_req_size;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_req_wdata;
    logic        dc_req_ready;
    logic        dc_rsp_valid;
    logic [31:0] dc_rsp_data;
    logic        l2_req_valid;
    logic [1:0]  l2_req_op;
    logic [1:0]  l2_req_size;
    logic [31:0] l2_req_addr;
    logic [31:0] l2_req_wdata;
    logic [1:0]  l2_req_src;
    logic        l2_req_ready;
    logic        l2_rsp_valid;
    logic [31:0] l2_rsp_data;
    logic [1:0]  fsm_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    bit          prefer_dc;
    logic [31:0] exp_ic_data;
    logic [31:0] exp_dc_data;

    // Clock and DUT.
    always #5 clk = ~clk;

    l1_to_l2_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .ic_req_valid (ic_req_valid),
        .ic_req_addr  (ic_req_addr),
        .ic_req_ready (ic_req_ready),
        .ic_rsp_valid (ic_rsp_valid),
        .ic_rsp_data  (ic_rsp_data),
        .dc_req_valid (dc_req_valid),
        .dc_req_op    (dc_req_op),
        .dc_req_size  (dc_req_size),
        .dc_req_addr  (dc_req_addr),
        .dc_req_wdata (dc_req_wdata),
        .dc_req_ready (dc_req_ready),
        .dc_rsp_valid (dc_rsp_valid),
        .dc_rsp_data  (dc_rsp_data),
        .l2_req_valid (l2_req_valid),
        .l2_req_op    (l2_req_op),
        .l2_req_size  (l2_req_size),
        .l2_req_addr  (l2_req_addr),
        .l2_req_wdata (l2_req_wdata),
        .l2_req_src   (l2_req_src),
        .l2_req_ready (l2_req_ready),
        .l2_rsp_valid (l2_rsp_valid),
        .l2_rsp_data  (l2_rsp_data),
        .fsm_state    (fsm_state)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        l2_req_ready = 1'b0;
        l2_rsp_valid = 1'b0;
        l2_rsp_data  = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            ic_req_valid = 1'b1;
            dc_req_valid = 1'b1;
            ic_req_addr  = $urandom;
            dc_req_addr  = $urandom;
            #1;
            n_cmp++;
            if ({ic_req_ready, dc_req_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_ready: got %b expected 00", {ic_req_ready, dc_req_ready});
            end
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        n_cmp++;
        if ({l2_req_valid, ic_rsp_valid, dc_rsp_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_valids: got %b expected 000", {l2_req_valid, ic_rsp_valid, dc_rsp_valid});
        end
        n_cmp++;
        if ({ic_rsp_data, dc_rsp_data} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h %h expected 0 0", ic_rsp_data, dc_rsp_data);
        end
        n_cmp++;
        if ({l2_req_op, l2_req_size, l2_req_addr, l2_req_wdata, l2_req_src, fsm_state} !== {4'd0, 64'd0, SRC_NONE, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_hold: got op %0d size %0d addr %h wdata %h src %0d state %0d expected all 0",
                     l2_req_op, l2_req_size, l2_req_addr, l2_req_wdata, l2_req_src, fsm_state);
        end
        tick();
        reset = 1'b0;
        #1;
        prefer_dc   = 1'b1;
        exp_ic_data = '0;
        exp_dc_data = '0;
    endtask

    // This task runs one full transaction. It is entered at a drive point, and
    // it returns at the drive point of the cycle where the response pulse is
    // checked. A following call therefore tests the next grant in that cycle.
    task automatic run_txn(input bit iv, input bit dv, input logic [1:0] op, input logic [1:0] size,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                           input int stall, input int lat, input bit spur, input logic [31:0] rdata);
        bit          win_dc;
        logic [1:0]  e_op, e_size, e_src;
        logic [31:0] e_addr, e_wdata;
        ic_req_valid = iv;
        dc_req_valid = dv;
        ic_req_addr  = ia;
        dc_req_op    = op;
        dc_req_size  = size;
        dc_req_addr  = da;
        dc_req_wdata = wd;
        l2_req_ready = 1'b0;
        l2_rsp_valid = 1'b0;
        #1;
        win_dc = dv && (!iv || prefer_dc);
        n_cmp++;
        if ({ic_req_ready, dc_req_ready} !== {!win_dc, win_dc}) begin
            n_fail++;
            $display("FAIL grant: ic/dc ready got %b expected %b", {ic_req_ready, dc_req_ready}, {!win_dc, win_dc});
        end
        prefer_dc = !win_dc;
        if (win_dc) begin
            e_op = op; e_size = size; e_addr = da; e_wdata = wd; e_src = SRC_DC;
        end else begin
            e_op = OP_LOAD; e_size = SZ_WORD; e_addr = ia; e_wdata = '0; e_src = SRC_IC;
        end

        // Issue phase. Both caches keep requesting so that a stray grant would show.
        for (int i = 0; i <= stall; i++) begin
            tick();
            ic_req_valid = 1'b1;
            dc_req_valid = 1'b1;
            ic_req_addr  = $urandom;
            dc_req_addr  = $urandom;
            l2_req_ready = (i == stall);
            l2_rsp_valid = spur;
            l2_rsp_data  = $urandom;
            #1;
            n_cmp++;
            if (l2_req_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL issue_valid: cycle %0d got %b expected 1", i, l2_req_valid);
            end
            n_cmp++;
            if ({l2_req_op, l2_req_size, l2_req_src, l2_req_addr, l2_req_wdata} !== {e_op, e_size, e_src, e_addr, e_wdata}) begin
                n_fail++;
                $display("FAIL issue_fields: got op %0d size %0d src %0d addr %h wdata %h expected op %0d size %0d src %0d addr %h wdata %h",
                         l2_req_op, l2_req_size, l2_req_src, l2_req_addr, l2_req_wdata, e_op, e_size, e_src, e_addr, e_wdata);
            end
            n_cmp++;
            if ({ic_req_ready, dc_req_ready, ic_rsp_valid, dc_rsp_valid} !== 4'b0000) begin
                n_fail++;
                $display("FAIL issue_quiet: ready/rsp got %b expected 0000", {ic_req_ready, dc_req_ready, ic_rsp_valid, dc_rsp_valid});
            end
            n_cmp++;
            if ({ic_rsp_data, dc_rsp_data} !== {exp_ic_data, exp_dc_data}) begin
                n_fail++;
                $display("FAIL rsp_data_hold: got %h %h expected %h %h", ic_rsp_data, dc_rsp_data, exp_ic_data, exp_dc_data);
            end
        end

        // Wait phase. The response arrives on iteration 'lat'.
        for (int j = 0; j <= lat; j++) begin
            tick();
            l2_req_ready = 1'b0;
            l2_rsp_valid = (j == lat);
            l2_rsp_data  = (j == lat) ? rdata : $urandom;
            #1;
            n_cmp++;
            if ({l2_req_valid, ic_req_ready, dc_req_ready, ic_rsp_valid, dc_rsp_valid} !== 5'b00000) begin
                n_fail++;
                $display("FAIL wait_quiet: got %b expected 00000",
                         {l2_req_valid, ic_req_ready, dc_req_ready, ic_rsp_valid, dc_rsp_valid});
            end
        end

        // Response pulse, one cycle after l2_rsp_valid.
        tick();
        l2_rsp_valid = 1'b0;
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        if (win_dc) exp_dc_data = rdata;
        else        exp_ic_data = rdata;
        #1;
        n_cmp++;
        if ({ic_rsp_valid, dc_rsp_valid} !== {!win_dc, win_dc}) begin
            n_fail++;
            $display("FAIL rsp_pulse: ic/dc got %b expected %b", {ic_rsp_valid, dc_rsp_valid}, {!win_dc, win_dc});
        end
        n_cmp++;
        if ({ic_rsp_data, dc_rsp_data} !== {exp_ic_data, exp_dc_data}) begin
            n_fail++;
            $display("FAIL rsp_data: got %h %h expected %h %h", ic_rsp_data, dc_rsp_data, exp_ic_data, exp_dc_data);
        end
    endtask

    task automatic test_single_load();
        run_txn(1'b0, 1'b1, OP_LOAD, SZ_WORD, 32'h0, 32'h100, 32'h0, 0, 1, 1'b0, 32'hDEADBEEF);
    endtask

    task automatic test_round_robin();
        test_reset();
        for (int k = 0; k < 4; k++) begin
            run_txn(1'b1, 1'b1, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                    $urandom, $urandom, $urandom, 0, 0, 1'b0, $urandom);
        end
    endtask

    task automatic test_store_stall();
        run_txn(1'b0, 1'b1, OP_STORE, SZ_BYTE, 32'h0, 32'h200, 32'hAB, 5, 0, 1'b0, $urandom);
    endtask

    task automatic test_clflush();
        run_txn(1'b0, 1'b1, OP_CLFLUSH, SZ_WORD, 32'h0, 32'h40, 32'h0, 1, 2, 1'b0, $urandom);
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 3; i++) begin
            tick();
            ic_req_valid = 1'b0;
            dc_req_valid = 1'b0;
            l2_rsp_valid = 1'b1;
            l2_rsp_data  = $urandom;
            #1;
            n_cmp++;
            if ({l2_req_valid, ic_rsp_valid, dc_rsp_valid, fsm_state} !== 5'b00000) begin
                n_fail++;
                $display("FAIL spur_idle: valid/rsp/state got %b expected 00000",
                         {l2_req_valid, ic_rsp_valid, dc_rsp_valid, fsm_state});
            end
        end
        l2_rsp_valid = 1'b0;
        // Stray responses during ISSUE, for both owners.
        run_txn(1'b1, 1'b0, OP_LOAD, SZ_WORD, 32'h3000, 32'h0, 32'h0, 2, 1, 1'b1, $urandom);
        run_txn(1'b0, 1'b1, OP_STORE, SZ_WORD, 32'h0, 32'h3004, $urandom, 3, 0, 1'b1, $urandom);
    endtask

    task automatic test_reset_mid();
        // A DCACHE grant leaves the ICACHE as the preferred requester. The reset
        // must then give the next tie back to the DCACHE.
        run_txn(1'b0, 1'b1, OP_LOAD, SZ_WORD, 32'h0, 32'h500, 32'h0, 0, 0, 1'b0, $urandom);
        tick();
        dc_req_valid = 1'b1;
        dc_req_op    = OP_LOAD;
        dc_req_addr  = 32'h600;
        #1;
        n_cmp++;
        if (dc_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_grant: dc_req_ready got %b expected 1", dc_req_ready);
        end
        tick();
        dc_req_valid = 1'b0;
        l2_req_ready = 1'b1;
        tick();
        l2_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        l2_rsp_valid = 1'b1;
        l2_rsp_data  = 32'hCAFEF00D;
        #1;
        n_cmp++;
        if ({l2_req_valid, ic_rsp_valid, dc_rsp_valid, l2_req_src} !== {3'b000, SRC_NONE}) begin
            n_fail++;
            $display("FAIL mid_reset_out: valid/rsp/src got %b expected 00000", {l2_req_valid, ic_rsp_valid, dc_rsp_valid, l2_req_src});
        end
        tick();
        l2_rsp_valid = 1'b0;
        #1;
        n_cmp++;
        if ({ic_rsp_valid, dc_rsp_valid, ic_rsp_data, dc_rsp_data} !== 66'd0) begin
            n_fail++;
            $display("FAIL mid_late_rsp: rsp valid %b%b data %h %h expected 00 0 0", ic_rsp_valid, dc_rsp_valid, ic_rsp_data, dc_rsp_data);
        end
        prefer_dc   = 1'b1;
        exp_ic_data = '0;
        exp_dc_data = '0;
        run_txn(1'b1, 1'b1, OP_STORE, SZ_WORD, 32'h700, 32'h704, $urandom, 0, 0, 1'b0, $urandom);
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            int sel;
            sel = $urandom_range(1, 3);
            run_txn(sel[0], sel[1], 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                    $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom);
        end
    endtask

    initial begin
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        ic_req_addr  = '0;
        dc_req_op    = '0;
        dc_req_size  = '0;
        dc_req_addr  = '0;
        dc_req_wdata = '0;
        l2_req_ready = 1'b0;
        l2_rsp_valid = 1'b0;
        l2_rsp_data  = '0;
        reset        = 1'b1;

        test_reset();
        test_single_load();
        test_round_robin();
        test_store_stall();
        test_clflush();
        test_spurious();
        test_reset_mid();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_to_l2_arbiter.md
L1_TO_L2_ARBITER -- requirements
Module: l1_to_l2_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all request addresses.
REQ-002 Parameter DATA_W, default 32, width of write data and response data.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ic_req_valid  input  1  ICACHE fill request; always a LOAD of size WORD.
REQ-006 ic_req_addr  input  ADDR_W  ICACHE request address.
REQ-007 ic_req_ready  output  1  ICACHE request accepted this cycle.
REQ-008 ic_rsp_valid  output  1  one-cycle pulse; response for ICACHE.
REQ-009 ic_rsp_data  output  DATA_W  ICACHE response data.
REQ-010 dc_req_valid  input  1  DCACHE request.
REQ-011 dc_req_op  input  2  memory_operation_e: STORE, LOAD or CLFLUSH.
REQ-012 dc_req_size  input  2  memory_operation_size_e: BYTE, HALF or WORD.
REQ-013 dc_req_addr  input  ADDR_W  DCACHE request address.
REQ-014 dc_req_wdata  input  DATA_W  DCACHE store data.
REQ-015 dc_req_ready  output  1  DCACHE request accepted this cycle.
REQ-016 dc_rsp_valid  output  1  one-cycle pulse; response for DCACHE.
REQ-017 dc_rsp_data  output  DATA_W  DCACHE response data.
REQ-018 l2_req_valid  output  1  request presented to L2CACHE.
REQ-019 l2_req_op / l2_req_size  output  2 / 2  held operation and size.
REQ-020 l2_req_addr / l2_req_wdata  output  ADDR_W / DATA_W  held address and data.
REQ-021 l2_req_src  output  2  cache_type_e of owner (ICACHE or DCACHE).
REQ-022 l2_req_ready  input  1  L2 accepts request when high with l2_req_valid.
REQ-023 l2_rsp_valid / l2_rsp_data  input  1 / DATA_W  L2 response; acknowledges every op, including STORE and CLFLUSH.

Function
REQ-024 FSM states IDLE, ISSUE, WAIT_RSP; exactly one transaction outstanding at any time.
REQ-025 IDLE: if any req_valid, grant one requester, assert its req_ready combinationally in that cycle, capture its fields into holding registers, go to ISSUE.
REQ-026 ic_req_ready and dc_req_ready are never high in the same cycle and are low outside IDLE.
REQ-027 ICACHE capture: op=LOAD, size=WORD, wdata=0, src=ICACHE; DCACHE capture: op/size/addr/wdata from dc_req_*, src=DCACHE.
REQ-028 Arbitration round-robin: with both valid, grant the requester not granted last; a single valid requester is granted regardless of priority.
REQ-029 Last-granted pointer updates only on a grant; after reset, DCACHE wins the first tie.
REQ-030 ISSUE: l2_req_valid=1 with held fields stable; on l2_req_ready=1 go to WAIT_RSP next cycle.
REQ-031 WAIT_RSP: on l2_rsp_valid=1, register l2_rsp_data into owner's rsp_data, pulse owner's rsp_valid next cycle, return to IDLE.
REQ-032 Minimum latency: grant at cycle N, l2_req_valid at N+1; L2 rsp at cycle M yields rsp_valid at M+1; new grant possible at M+1.
REQ-033 l2_rsp_valid in IDLE or ISSUE is ignored (no rsp pulse, no state change).
REQ-034 Non-owner rsp_valid stays 0; rsp_data holds last value when rsp_valid low.
REQ-035 l2_req_src, l2_req_op, l2_req_size, l2_req_addr, l2_req_wdata are stable from entry to ISSUE until the request handshake completes.

Reset
REQ-036 Reset dominates all inputs: state IDLE, priority pointer so DCACHE wins next tie, holding registers 0, l2_req_src=UNASSIGNED.
REQ-037 During and after reset: l2_req_valid=0, ic/dc_req_ready=0 while reset high, ic/dc_rsp_valid=0, ic/dc_rsp_data=0.
REQ-038 Reset asserted mid-transaction abandons it: no response pulse; late l2_rsp_valid after reset is ignored per REQ-033.

Verification
REQ-039 Single DCACHE LOAD addr 0x100, L2 ready immediately, rsp 0xDEADBEEF two cycles later -> dc_req_ready at N, l2_req_valid N+1 with op=LOAD, src=DCACHE; dc_rsp_valid one cycle after l2_rsp_valid, data 0xDEADBEEF.
REQ-040 Both valid continuously after reset, 4 transactions -> grant order DCACHE, ICACHE, DCACHE, ICACHE; ICACHE L2 requests show op=LOAD, size=WORD.
REQ-041 DCACHE STORE size=BYTE wdata 0xAB, l2_req_ready held low 5 cycles -> l2_req_valid high 5+ cycles with fields unchanged; no new grant until rsp.
REQ-042 DCACHE CLFLUSH addr 0x40 -> L2 sees op=CLFLUSH; dc_rsp_valid pulses once on L2 ack.
REQ-043 Spurious l2_rsp_valid in IDLE and in ISSUE -> no rsp_valid pulse, FSM unaffected.
REQ-044 Reset asserted in WAIT_RSP then L2 response arrives -> no rsp_valid, outputs at reset values, next tie granted to DCACHE.
